// File: rtl/fifo_sched_dna.sv
// Purpose: two-writer / one-reader sequencer for a shared DEPTH-word RAM; no data is stored here.
// Latency: grant and strobes are combinational (0 cycles); pointers, count and flags update on the next edge.
// Backpressure: writes are refused while full, even with a read in the same cycle; reads while empty are ignored.
// Optional feature: define FIFO_SCHED_DNA_ALMOST_EN to add the registered almost_full output.
module fifo_sched_dna #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            gnt,
  input  logic                  rd,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_SCHED_DNA_ALMOST_EN
  ,
  output logic                  almost_full
`endif
);

  localparam int              DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_CNT    = AF_LEVEL[ADDR_WIDTH:0];

  // prio = 0 prefers requester 0, prio = 1 prefers requester 1
  logic                prio;
  logic [ADDR_WIDTH:0] count_nxt;

  // Strobes and round-robin grant; everything is held off while reset is asserted
  always_comb begin
    gnt   = 2'b00;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (reset_n) begin
      wr_en = (req != 2'b00) && !full;
      rd_en = rd && !empty;
    end
    if (wr_en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Forward the granted requester's data; zero when nobody is granted
  always_comb begin
    wdata = '0;
    case (gnt)
      2'b01:   wdata = wdata0;
      2'b10:   wdata = wdata1;
      default: wdata = '0;
    endcase
  end

  // Next occupancy: simultaneous write and read cancel out
  always_comb begin
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers wrap naturally at DEPTH because they are exactly ADDR_WIDTH bits wide
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_addr <= '0;
      r_addr <= '0;
    end else begin
      if (wr_en) w_addr <= w_addr + 1'b1;
      if (rd_en) r_addr <= r_addr + 1'b1;
    end
  end

  // Occupancy and flags, all derived from the same next-count value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      empty <= (count_nxt == '0);
    end
  end

  // Priority passes to the requester that was not served whenever a grant happens
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio <= 1'b0;
    end else if (gnt != 2'b00) begin
      prio <= gnt[0];
    end
  end

`ifdef FIFO_SCHED_DNA_ALMOST_EN
  // Almost-full threshold flag, registered alongside full/empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_nxt >= AF_CNT);
    end
  end
`else
  // Threshold has no consumer in this build
  logic unused_af_cnt;
  assign unused_af_cnt = ^AF_CNT;
`endif

endmodule

// File: tb/tb_fifo_sched_dna.sv
// Directed-vector bench for fifo_sched_dna with DEPTH=4, AF_LEVEL=3.
// Driver applies one vector per cycle just after the rising edge and queues its expected outputs.
// Monitor samples on the falling edge and compares against the queue head.
module tb_fifo_sched_dna;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          rd = 1'b0;
  logic [1:0]    gnt;
  logic          wr_en, rd_en;
  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] wdata;
  logic          full, empty;
  logic [AW:0]   count;
  logic          af_obs;

  typedef struct {
    int            cyc;
    logic [1:0]    gnt;
    logic          we;
    logic          re;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [DW-1:0] wd;
    logic          full;
    logic          empty;
    logic [AW:0]   cnt;
    logic          af;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_popped = 0;
  int   n_pushed = 0;
  int   cyc      = 0;
  bit   drv_done = 1'b0;

  fifo_sched_dna #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(3)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rd(rd), .wr_en(wr_en), .rd_en(rd_en), .w_addr(w_addr), .r_addr(r_addr),
    .wdata(wdata), .full(full), .empty(empty), .count(count)
`ifdef FIFO_SCHED_DNA_ALMOST_EN
    , .almost_full(af_obs)
`endif
  );

`ifndef FIFO_SCHED_DNA_ALMOST_EN
  assign af_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, c, act, req_v);
    end
  endtask

  // One directed vector: inputs for this cycle plus the hand-computed outputs seen during it
  task automatic vec(input logic rn, input logic [1:0] rq, input logic r,
                     input logic [1:0] eg, input logic ewe, input logic ere,
                     input int ewa, input int era, input logic ef, input logic ee,
                     input int ecnt, input logic eaf);
    exp_t e;
    logic [DW-1:0] d0, d1;
    @(posedge clk);
    #1;
    d0 = DW'(8'hA0 + cyc);
    d1 = DW'(8'hB0 + cyc);
    reset_n = rn;
    req     = rq;
    rd      = r;
    wdata0  = d0;
    wdata1  = d1;
    e.cyc   = cyc;
    e.gnt   = eg;
    e.we    = ewe;
    e.re    = ere;
    e.wa    = AW'(ewa);
    e.ra    = AW'(era);
    e.wd    = (eg == 2'b01) ? d0 : (eg == 2'b10) ? d1 : '0;
    e.full  = ef;
    e.empty = ee;
    e.cnt   = (AW+1)'(ecnt);
    e.af    = eaf;
    exp_q.push_back(e);
    n_pushed++;
    cyc++;
  endtask

  // Monitor: compare every presented output sample against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_popped++;
      chk("gnt",   e.cyc, 32'(gnt),    32'(e.gnt));
      chk("wr_en", e.cyc, 32'(wr_en),  32'(e.we));
      chk("rd_en", e.cyc, 32'(rd_en),  32'(e.re));
      chk("w_addr",e.cyc, 32'(w_addr), 32'(e.wa));
      chk("r_addr",e.cyc, 32'(r_addr), 32'(e.ra));
      chk("wdata", e.cyc, 32'(wdata),  32'(e.wd));
      chk("full",  e.cyc, 32'(full),   32'(e.full));
      chk("empty", e.cyc, 32'(empty),  32'(e.empty));
      chk("count", e.cyc, 32'(count),  32'(e.cnt));
`ifdef FIFO_SCHED_DNA_ALMOST_EN
      chk("almost_full", e.cyc, 32'(af_obs), 32'(e.af));
`endif
    end
  end

  // Stimulus:  rn  req    rd | gnt   we re wa ra full empty cnt af
  initial begin
    vec(0, 2'b11, 1,  2'b00, 0, 0, 0, 0, 0, 1, 0, 0);  // reset: outputs held off
    vec(1, 2'b01, 0,  2'b01, 1, 0, 0, 0, 0, 1, 0, 0);  // fill with requester 0
    vec(1, 2'b01, 0,  2'b01, 1, 0, 1, 0, 0, 0, 1, 0);
    vec(1, 2'b01, 0,  2'b01, 1, 0, 2, 0, 0, 0, 2, 0);
    vec(1, 2'b01, 0,  2'b01, 1, 0, 3, 0, 0, 0, 3, 1);
    vec(1, 2'b11, 1,  2'b00, 0, 1, 0, 0, 1, 0, 4, 1);  // full: write blocked, read proceeds
    vec(1, 2'b00, 0,  2'b00, 0, 0, 0, 1, 0, 0, 3, 1);
    vec(1, 2'b00, 1,  2'b00, 0, 1, 0, 1, 0, 0, 3, 1);  // read drops below threshold
    vec(1, 2'b00, 0,  2'b00, 0, 0, 0, 2, 0, 0, 2, 0);
    vec(1, 2'b01, 1,  2'b01, 1, 1, 0, 2, 0, 0, 2, 0);  // simultaneous write+read
    vec(1, 2'b10, 1,  2'b10, 1, 1, 1, 3, 0, 0, 2, 0);  // read pointer wraps 3->0
    vec(1, 2'b00, 0,  2'b00, 0, 0, 2, 0, 0, 0, 2, 0);
    vec(1, 2'b00, 1,  2'b00, 0, 1, 2, 0, 0, 0, 2, 0);  // drain
    vec(1, 2'b00, 1,  2'b00, 0, 1, 2, 1, 0, 0, 1, 0);
    vec(1, 2'b00, 1,  2'b00, 0, 0, 2, 2, 0, 1, 0, 0);  // read while empty ignored
    vec(1, 2'b00, 1,  2'b00, 0, 0, 2, 2, 0, 1, 0, 0);
    vec(1, 2'b11, 0,  2'b01, 1, 0, 2, 2, 0, 1, 0, 0);  // both request: alternate
    vec(1, 2'b11, 0,  2'b10, 1, 0, 3, 2, 0, 0, 1, 0);
    vec(1, 2'b11, 0,  2'b01, 1, 0, 0, 2, 0, 0, 2, 0);
    vec(1, 2'b11, 0,  2'b10, 1, 0, 1, 2, 0, 0, 3, 1);
    vec(1, 2'b11, 0,  2'b00, 0, 0, 2, 2, 1, 0, 4, 1);  // full: no grant
    vec(1, 2'b00, 1,  2'b00, 0, 1, 2, 2, 1, 0, 4, 1);
    vec(1, 2'b01, 1,  2'b01, 1, 1, 2, 3, 0, 0, 3, 1);  // leaves requester 1 preferred
    vec(0, 2'b11, 1,  2'b00, 0, 0, 0, 0, 0, 1, 0, 0);  // reset mid-operation at count 3
    vec(1, 2'b11, 0,  2'b01, 1, 0, 0, 0, 0, 1, 0, 0);  // requester 0 preferred again
    vec(1, 2'b11, 0,  2'b10, 1, 0, 1, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    req = 2'b00;
    rd  = 1'b0;
    drv_done = 1'b1;
  end

  // Bounded wait for the monitor to drain the queue, then report
  initial begin
    int budget;
    budget = 0;
    wait (drv_done);
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    n_checks++;
    if (n_popped != n_pushed) begin
      n_fail++;
      $display("FAIL drain samples_checked=%0d required=%0d", n_popped, n_pushed);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #50000;
    $display("FAIL watchdog time_limit_reached=1 required=0");
    $fatal(1, "timeout");
  end

endmodule
